data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 32, the memory byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the memory data width.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset; clk and rst_n are the first two ports.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 req0, req1  input  1 each  access request from requester 0 (core load/store unit) and requester 1 (loader/debug port).
REQ-007 we0, we1  input  1 each  1 = store, 0 = load.
REQ-008 mode0, mode1  input  1 each  1 = byte access, 0 = word access.
REQ-009 addr0, addr1  input  ADDRESS_WIDTH each  byte address.
REQ-010 wdata0, wdata1  input  DATA_WIDTH each  store data; byte stores use bits [7:0].
REQ-011 gnt0, gnt1  output  1 each  request accepted this cycle.
REQ-012 rvalid0, rvalid1  output  1 each  response valid; one-cycle pulse.
REQ-013 rdata0, rdata1  output  DATA_WIDTH each  registered load data.
REQ-014 err0, err1  output  1 each  misaligned-access flag; qualified by rvalid.
REQ-015 mem_WE  output  1  memory write enable.
REQ-016 mem_addr_mode  output  1  memory byte/word select.
REQ-017 mem_A  output  ADDRESS_WIDTH  memory address.
REQ-018 mem_WD  output  DATA_WIDTH  memory write data.
REQ-019 mem_RD  input  DATA_WIDTH  memory combinational read data.

Function
REQ-020 At most one of gnt0/gnt1 SHALL be high in any cycle; gntX is combinational from reqX and arbiter state, and only high while reqX is high.
REQ-021 Single requester: the block SHALL grant it in the same cycle.
REQ-022 Both requesting: the block SHALL grant the port not granted most recently (round-robin); the last_grant register updates on every grant.
REQ-023 In a grant cycle, mem_A, mem_addr_mode and mem_WD SHALL equal the granted port's addrX, modeX and wdataX; mem_WE = weX AND NOT misaligned.
REQ-024 With no grant, mem_WE SHALL be 0 and mem_A, mem_addr_mode and mem_WD SHALL be 0.
REQ-025 Misaligned means a word access (modeX = 0) with addrX[1:0] != 0; byte accesses are never misaligned.
REQ-026 For a granted access in cycle N, rvalidX SHALL be high in cycle N+1 only; latency is exactly 1 cycle, for loads and stores alike.
REQ-027 Granted aligned load: rdataX SHALL capture mem_RD at the end of cycle N and hold it until the next response to that port.
REQ-028 Granted store: rdataX SHALL be unchanged; errX = 0.
REQ-029 Granted misaligned access: no memory write occurs; rvalidX = 1 and errX = 1 in N+1; rdataX = 0.
REQ-030 errX SHALL be 0 whenever rvalidX = 0.
REQ-031 Back-to-back grants SHALL be allowed every cycle with no idle cycle between accesses.
REQ-032 A requester SHALL hold reqX, weX, modeX, addrX and wdataX stable until gntX; the block does not buffer ungranted requests.
REQ-033 Starvation bound: with both ports requesting continuously, a waiting port SHALL be granted within 2 cycles.
REQ-034 Dropping reqX before grant: the request is abandoned; no memory side effect and no response.

Reset
REQ-035 While rst_n = 0 at a rising edge, the block SHALL set gnt0/gnt1 = 0, rvalid0/rvalid1 = 0, err0/err1 = 0, rdata0/rdata1 = 0, mem_WE = 0, and last_grant = port 1, so port 0 wins the first contention.
REQ-036 Reset asserted in a grant cycle: the block SHALL suppress the pending response, and mem_WE SHALL be 0 during every reset cycle.

Verification
REQ-037 After reset: req0 = 1 and req1 = 1, both word loads, addr0 = 0x10, addr1 = 0x20, mem holding 0xAABBCCDD at 0x10 -> gnt0 in cycle 0; rvalid0 = 1 and rdata0 = 0xAABBCCDD in cycle 1; gnt1 in cycle 1.
REQ-038 Both ports request continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; never both high.
REQ-039 Port 1 word store 0x12345678 to 0x40, then port 0 byte load of 0x41 -> rdata0 = 0x00000056 one cycle after its grant.
REQ-040 Port 0 word store to 0x42 (misaligned) -> mem_WE = 0 in the grant cycle; rvalid0 = 1, err0 = 1, rdata0 = 0 next cycle; memory unchanged.
REQ-041 rst_n = 0 in the cycle port 1 is granted a load -> rvalid1 stays 0; after release, first contention grants port 0.
REQ-042 req1 = 1 for 2 cycles then dropped while port 0 holds continuous requests -> port 1 is granted at most once; rvalid1 pulses once.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port round-robin arbiter in front of a single data memory

module data_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic                     mode0,
  input  logic                     mode1,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [DATA_WIDTH-1:0]    rdata0,
  output logic [DATA_WIDTH-1:0]    rdata1,
  output logic                     err0,
  output logic                     err1,
  output logic                     mem_WE,
  output logic                     mem_addr_mode,
  output logic [ADDRESS_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0]    mem_WD,
  input  logic [DATA_WIDTH-1:0]    mem_RD
);

  // Arbiter state remembers which port was granted most recently.
  typedef enum logic {
    LAST_P0 = 1'b0,
    LAST_P1 = 1'b1
  } arb_state_t;

  arb_state_t state_q;
  arb_state_t state_d;

  // Word accesses must be 4-byte aligned; byte accesses never fault.
  logic mis0;
  logic mis1;

  assign mis0 = ~mode0 & (addr0[1:0] != 2'b00);
  assign mis1 = ~mode1 & (addr1[1:0] != 2'b00);

  // Arbiter state register; reset favours port 0 at the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LAST_P1;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant selection and memory-port mux; grants are held off during reset.
  always_comb begin
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    state_d       = state_q;
    mem_WE        = 1'b0;
    mem_addr_mode = 1'b0;
    mem_A         = '0;
    mem_WD        = '0;

    if (rst_n) begin
      if (req0 && req1) begin
        if (state_q == LAST_P1) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end

    if (gnt0) begin
      state_d       = LAST_P0;
      mem_WE        = we0 & ~mis0;
      mem_addr_mode = mode0;
      mem_A         = addr0;
      mem_WD        = wdata0;
    end else if (gnt1) begin
      state_d       = LAST_P1;
      mem_WE        = we1 & ~mis1;
      mem_addr_mode = mode1;
      mem_A         = addr1;
      mem_WD        = wdata1;
    end
  end

  // Port 0 response: one-cycle pulse, load data captured, faults clear rdata.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      err0    <= 1'b0;
      rdata0  <= '0;
    end else begin
      rvalid0 <= gnt0;
      err0    <= gnt0 & mis0;
      if (gnt0) begin
        if (mis0) begin
          rdata0 <= '0;
        end else if (!we0) begin
          rdata0 <= mem_RD;
        end
      end
    end
  end

  // Port 1 response: same behaviour as port 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid1 <= 1'b0;
      err1    <= 1'b0;
      rdata1  <= '0;
    end else begin
      rvalid1 <= gnt1;
      err1    <= gnt1 & mis1;
      if (gnt1) begin
        if (mis1) begin
          rdata1 <= '0;
        end else if (!we1) begin
          rdata1 <= mem_RD;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter

module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1, mode0, mode1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_WE, mem_addr_mode;
  logic [31:0] mem_A, mem_WD, mem_RD;

  logic [31:0] mem [0:255];

  int checks;
  int failures;

  data_mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .mode0(mode0), .mode1(mode1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_WE(mem_WE), .mem_addr_mode(mem_addr_mode), .mem_A(mem_A),
    .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian memory model: byte reads return the zero-extended byte.
  always_comb begin
    logic [31:0] word;
    word = mem[mem_A[9:2]];
    if (mem_addr_mode) begin
      mem_RD = (word >> (8 * mem_A[1:0])) & 32'h0000_00FF;
    end else begin
      mem_RD = word;
    end
  end

  // Memory writes; preloaded contents are restored while reset is low.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[32'h10 >> 2] <= 32'hAABB_CCDD;
      mem[32'h20 >> 2] <= 32'h1122_3344;
    end else if (mem_WE) begin
      if (mem_addr_mode) begin
        case (mem_A[1:0])
          2'd0: mem[mem_A[9:2]][7:0]   <= mem_WD[7:0];
          2'd1: mem[mem_A[9:2]][15:8]  <= mem_WD[7:0];
          2'd2: mem[mem_A[9:2]][23:16] <= mem_WD[7:0];
          default: mem[mem_A[9:2]][31:24] <= mem_WD[7:0];
        endcase
      end else begin
        mem[mem_A[9:2]] <= mem_WD;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; mode0 = 0; mode1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  int g0_cnt, g1_cnt, rv1_cnt;

  initial begin
    checks = 0;
    failures = 0;
    idle_inputs();
    rst_n = 0;

    // Reset: a pending store must neither be granted nor write memory.
    #1;
    req0 = 1; we0 = 1; addr0 = 32'h80; wdata0 = 32'hDEAD_BEEF;
    #1;
    check("rst_gnt0", gnt0, 0);
    check("rst_mem_we", mem_WE, 0);
    step();
    step();
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_err0", err0, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_mem_we2", mem_WE, 0);
    idle_inputs();
    rst_n = 1;
    step();

    // Both load at once: port 0 first, then port 1 in the next cycle.
    req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h20;
    #1;
    check("c0_gnt0", gnt0, 1);
    check("c0_gnt1", gnt1, 0);
    check("c0_mem_a", mem_A, 32'h10);
    check("c0_mem_we", mem_WE, 0);
    step();
    req0 = 0;
    #1;
    check("c1_rvalid0", rvalid0, 1);
    check("c1_rdata0", rdata0, 32'hAABB_CCDD);
    check("c1_err0", err0, 0);
    check("c1_gnt1", gnt1, 1);
    check("c1_gnt0", gnt0, 0);
    step();
    req1 = 0;
    #1;
    check("c2_rvalid1", rvalid1, 1);
    check("c2_rdata1", rdata1, 32'h1122_3344);
    check("c2_rvalid0", rvalid0, 0);
    check("idle_mem_a", mem_A, 0);
    step();

    // Continuous contention alternates grants starting with port 0.
    req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h20;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rr_gnt0_%0d", i), gnt0, (i % 2) == 0);
      check($sformatf("rr_gnt1_%0d", i), gnt1, (i % 2) == 1);
      check($sformatf("rr_both_%0d", i), gnt0 & gnt1, 0);
      step();
    end
    idle_inputs();
    step();

    // Port 1 word store, then port 0 byte load of byte 1.
    req1 = 1; we1 = 1; mode1 = 0; addr1 = 32'h40; wdata1 = 32'h1234_5678;
    #1;
    check("st_gnt1", gnt1, 1);
    check("st_mem_we", mem_WE, 1);
    check("st_mem_wd", mem_WD, 32'h1234_5678);
    step();
    idle_inputs();
    req0 = 1; we0 = 0; mode0 = 1; addr0 = 32'h41;
    #1;
    check("st_rvalid1", rvalid1, 1);
    check("st_err1", err1, 0);
    check("st_rdata1_hold", rdata1, 32'h1122_3344);
    check("bl_gnt0", gnt0, 1);
    check("bl_mode", mem_addr_mode, 1);
    step();
    idle_inputs();
    #1;
    check("bl_rvalid0", rvalid0, 1);
    check("bl_rdata0", rdata0, 32'h0000_0056);
    step();

    // Misaligned word store: no write, error response with zero data.
    req0 = 1; we0 = 1; mode0 = 0; addr0 = 32'h42; wdata0 = 32'hCAFE_BABE;
    #1;
    check("mis_gnt0", gnt0, 1);
    check("mis_mem_we", mem_WE, 0);
    step();
    idle_inputs();
    #1;
    check("mis_rvalid0", rvalid0, 1);
    check("mis_err0", err0, 1);
    check("mis_rdata0", rdata0, 0);
    check("mis_mem", mem[32'h40 >> 2], 32'h1234_5678);
    step();
    check("mis_rvalid0_drop", rvalid0, 0);
    check("mis_err0_drop", err0, 0);

    // Reset during a port 1 load suppresses the response.
    req1 = 1; we1 = 0; addr1 = 32'h20; rst_n = 0;
    #1;
    check("rg_gnt1", gnt1, 0);
    check("rg_mem_we", mem_WE, 0);
    step();
    req1 = 0; rst_n = 1;
    #1;
    check("rg_rvalid1", rvalid1, 0);
    check("rg_rdata1", rdata1, 0);
    req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h20;
    #1;
    check("rg_first_gnt0", gnt0, 1);
    check("rg_first_gnt1", gnt1, 0);
    step();
    idle_inputs();
    step();

    // Port 1 requests for two cycles beside continuous port 0 traffic.
    g0_cnt = 0; g1_cnt = 0; rv1_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      req0 = 1; addr0 = 32'h10;
      req1 = (i < 2); addr1 = 32'h20;
      #1;
      check($sformatf("drop_both_%0d", i), gnt0 & gnt1, 0);
      g0_cnt += int'(gnt0);
      g1_cnt += int'(gnt1);
      step();
      rv1_cnt += int'(rvalid1);
    end
    idle_inputs();
    step();
    rv1_cnt += int'(rvalid1);
    check("drop_gnt1_cnt", g1_cnt, 1);
    check("drop_rvalid1_cnt", rv1_cnt, 1);
    check("drop_gnt0_cnt", g0_cnt, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
